// File: rtl/hazard_if.sv
// Decode-to-hazard-unit bundle: decode-stage instruction fields in, stall and
// forwarding controls out.
//   master : pipeline side (drives decode fields, consumes controls)
//   slave  : hazard unit side (consumes decode fields, drives controls)
interface hazard_if #(
   parameter int unsigned REG_BITS = 5,
   parameter int unsigned CNT_W    = 16
);
   // decode-stage fields
   logic                valid_d;
   logic [REG_BITS-1:0] rs_d;
   logic [REG_BITS-1:0] rt_d;
   logic                uses_rs_d;
   logic                uses_rt_d;
   logic [REG_BITS-1:0] dest_d;
   logic                wb_en_d;
   logic                mem_r_d;
   logic                is_branch_d;
   logic                is_jr_d;
   logic                terminate_d;
   // hazard controls
   logic                harzard;
   logic                stall_f;
   logic                fwd_rs_d;
   logic                fwd_rt_d;
   logic [1:0]          fwd_a_e;
   logic [1:0]          fwd_b_e;
   logic                draining;
   logic                halt;
   logic [CNT_W-1:0]    stall_cnt;

   modport master (
      output valid_d, rs_d, rt_d, uses_rs_d, uses_rt_d, dest_d, wb_en_d,
             mem_r_d, is_branch_d, is_jr_d, terminate_d,
      input  harzard, stall_f, fwd_rs_d, fwd_rt_d, fwd_a_e, fwd_b_e,
             draining, halt, stall_cnt
   );

   modport slave (
      input  valid_d, rs_d, rt_d, uses_rs_d, uses_rt_d, dest_d, wb_en_d,
             mem_r_d, is_branch_d, is_jr_d, terminate_d,
      output harzard, stall_f, fwd_rs_d, fwd_rt_d, fwd_a_e, fwd_b_e,
             draining, halt, stall_cnt
   );
endinterface

// File: rtl/hazard_unit.sv
// Pipeline hazard unit for a 5-stage pipeline.
// Tracks a shadow scoreboard of EX/MEM/WB destinations fed from decode, raises
// the decode stall (harzard) for load-use and D-stage branch/jr hazards,
// produces D-stage and EX-stage forwarding selects, and drains the pipeline to
// a sticky halt after terminate.
// Ports:
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : hazard_if slave (decode fields in, stall/forward/halt controls out)
module hazard_unit #(
   parameter int unsigned REG_BITS    = 5,
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned DRAIN_DEPTH = 3
) (
   input logic     clk,
   input logic     rst_n,
   hazard_if.slave bus
);

   localparam int unsigned DCNT_W = $clog2(DRAIN_DEPTH + 1);

   typedef struct packed {
      logic [REG_BITS-1:0] dest;
      logic [REG_BITS-1:0] rs;
      logic [REG_BITS-1:0] rt;
      logic                wb_en;
      logic                mem_r;
   } sb_entry_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      HALT  = 2'd2
   } drain_state_t;

   sb_entry_t        ex_q;
   sb_entry_t        mem_q;
   sb_entry_t        wb_q;
   drain_state_t     state_q;
   logic [DCNT_W-1:0] dcnt_q;
   logic [CNT_W-1:0] stall_cnt_q;

   logic draining;
   logic halt;
   logic rs_ex;
   logic rt_ex;
   logic rs_mem_ld;
   logic rt_mem_ld;
   logic load_use;
   logic branch_stall;
   logic harzard_c;
   logic take_d;

   // A stage supplies index idx only if it writes back a non-zero register.
   function automatic logic hits(input logic [REG_BITS-1:0] idx, input sb_entry_t e);
      return e.wb_en && (e.dest != '0) && (idx == e.dest);
   endfunction

   // Stall detection against the scoreboard.
   always_comb begin
      draining     = (state_q == DRAIN);
      halt         = (state_q == HALT);
      rs_ex        = bus.uses_rs_d && hits(bus.rs_d, ex_q);
      rt_ex        = bus.uses_rt_d && hits(bus.rt_d, ex_q);
      rs_mem_ld    = bus.uses_rs_d && hits(bus.rs_d, mem_q) && mem_q.mem_r;
      rt_mem_ld    = bus.uses_rt_d && hits(bus.rt_d, mem_q) && mem_q.mem_r;
      load_use     = ex_q.mem_r && (rs_ex || rt_ex);
      branch_stall = (bus.is_branch_d || bus.is_jr_d) &&
                     (rs_ex || rt_ex || rs_mem_ld || rt_mem_ld);
      harzard_c    = bus.valid_d && (load_use || branch_stall) && !draining && !halt;
      // Decode instruction advances this cycle (stall or drain blocks it).
      take_d       = bus.valid_d && !harzard_c && !draining && !halt;
   end

   assign bus.harzard   = harzard_c;
   assign bus.stall_f   = harzard_c || draining || halt;
   // Load data is not yet available in MEM, so only ALU results forward to D.
   assign bus.fwd_rs_d  = hits(bus.rs_d, mem_q) && !mem_q.mem_r;
   assign bus.fwd_rt_d  = hits(bus.rt_d, mem_q) && !mem_q.mem_r;
   // MEM holds the younger result, so it wins over WB.
   assign bus.fwd_a_e   = hits(ex_q.rs, mem_q) ? 2'b10 :
                          hits(ex_q.rs, wb_q)  ? 2'b01 : 2'b00;
   assign bus.fwd_b_e   = hits(ex_q.rt, mem_q) ? 2'b10 :
                          hits(ex_q.rt, wb_q)  ? 2'b01 : 2'b00;
   assign bus.draining  = draining;
   assign bus.halt      = halt;
   assign bus.stall_cnt = stall_cnt_q;

   // Scoreboard shift, stall statistics and drain FSM.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ex_q        <= '0;
         mem_q       <= '0;
         wb_q        <= '0;
         state_q     <= IDLE;
         dcnt_q      <= '0;
         stall_cnt_q <= '0;
      end else begin
         wb_q  <= mem_q;
         mem_q <= ex_q;
         // Terminate itself travels down the pipe as a bubble.
         if (take_d && !bus.terminate_d) begin
            ex_q <= '{dest:  bus.dest_d,
                      rs:    bus.rs_d,
                      rt:    bus.rt_d,
                      wb_en: bus.wb_en_d,
                      mem_r: bus.mem_r_d};
         end else begin
            ex_q <= '0;
         end

         if (harzard_c && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         end

         case (state_q)
            IDLE: begin
               if (take_d && bus.terminate_d) begin
                  state_q <= DRAIN;
                  dcnt_q  <= DCNT_W'(DRAIN_DEPTH);
               end
            end
            DRAIN: begin
               if (dcnt_q == DCNT_W'(1)) begin
                  state_q <= HALT;
                  dcnt_q  <= '0;
               end else begin
                  dcnt_q  <= dcnt_q - DCNT_W'(1);
               end
            end
            HALT: begin
               state_q <= HALT;
            end
            default: begin
               state_q <= IDLE;
               dcnt_q  <= '0;
            end
         endcase
      end
   end

endmodule
